// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the two-phase (toggle) handshake endpoints, used by
// toggle_hs_rx and the planned toggle_hs_tx.
package toggle_hs_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef logic [0:0] hs_state_t;

  localparam hs_state_t IDLE = 1'b0;
  localparam hs_state_t HOLD = 1'b1;

  // A two-phase event is any level change relative to the last seen level.
  function automatic logic toggled(input logic cur, input logic prev);
    return cur ^ prev;
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-bit 2-flop synchronizer with asynchronous clear; only built when
// TOGGLE_HS_RX_SYNC_EN is defined, since nothing else instantiates it.
`ifdef TOGGLE_HS_RX_SYNC_EN
module toggle_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/toggle_hs_rx.sv
// Responder side of a toggle (two-phase) bundled-data handshake: converts
// req_t level changes into valid/ready words. Define TOGGLE_HS_RX_SYNC_EN to
// synchronize req_t from another clock domain.
module toggle_hs_rx
  import toggle_hs_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_t,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_t,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              overrun
);

  logic      req_s;
  logic      req_prev;
  logic      tog;
  hs_state_t state;

`ifdef TOGGLE_HS_RX_SYNC_EN
  toggle_sync #(
    .WIDTH(1)
  ) u_req_sync (
    .clk(clk),
    .clr(clr),
    .d  (req_t),
    .q  (req_s)
  );
`else
  assign req_s = req_t;
`endif

  assign tog = toggled(req_s, req_prev);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      req_prev   <= 1'b0;
      ack_t      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      xfer_count <= '0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tog) begin
            dout       <= data_in;
            dout_valid <= 1'b1;
            req_prev   <= req_s;
            state      <= HOLD;
          end
        end
        HOLD: begin
          // A toggle while a word is outstanding is dropped: it is absorbed
          // into req_prev so it never produces a word or an ack.
          if (tog) begin
            overrun  <= 1'b1;
            req_prev <= req_s;
          end
          if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            ack_t      <= ~ack_t;
            xfer_count <= xfer_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/toggle_hs_rx.md
Name: toggle_hs_rx

Overview:
- Responder end of a two-phase (toggle) bundled-data handshake for the 16-bit CPU datapath.
- An initiator toggles req_t to present a word on data_in. This block detects the toggle and captures the word into an output register.
- It offers the word downstream with a valid/ready pair. When the word is consumed, it toggles ack_t back to the initiator.
- It is the decoder counterpart of a toggle flip-flop: level changes go in, single transactions come out.

Parameters:
- DATA_W, 16, width of data_in/dout.
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-high reset.
- req_t  input  1  request toggle from initiator; each level change = one new word.
- data_in  input  DATA_W  bundled data; initiator holds it stable from the req_t toggle until the matching ack_t toggle.
- ack_t  output  1  acknowledge toggle to initiator.
- dout  output  DATA_W  captured word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  downstream accepts dout this cycle.
- xfer_count  output  CNT_W  number of completed transfers.
- overrun  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (clr=1, asynchronous):
  - ack_t=0, dout=0, dout_valid=0, xfer_count=0, overrun=0.
  - Internal req_prev=0, state=IDLE, synchronizer flops=0.
  - Initiator shares clr, so req_t=0 after reset.
- Sampled request and toggle detect:
  - req_s = req_t (macro off) or 2-flop synchronized req_t (macro on).
  - tog = req_s XOR req_prev.
- State IDLE:
  - If tog at a rising edge: dout<=data_in, dout_valid<=1, req_prev<=req_s, state<=HOLD.
  - Otherwise hold.
- State HOLD:
  - If dout_valid && dout_ready at the edge: dout_valid<=0, ack_t<=~ack_t, xfer_count<=xfer_count+1, state<=IDLE.
  - dout is stable throughout HOLD.
- Latency, macro off: req_t toggles before edge N → dout_valid=1 after edge N. Ready at edge N+1 → ack_t toggles and dout_valid=0 after edge N+1.
- Back-to-back: a new req_t toggle may arrive only after ack_t toggles. A toggle seen in IDLE in the cycle after ack is captured normally, giving 2-cycle throughput with ready held high.
- Violation: in HOLD, if req_s != req_prev at an edge:
  - overrun<=1 (sticky until clr) and req_prev<=req_s.
  - The extra request is dropped; no ack is issued for it.
  - The current word is unaffected.
- Counter: xfer_count wraps modulo 2^CNT_W (255 → 0 for the default).
- dout_ready while dout_valid=0 is ignored.
- Reset mid-HOLD: word discarded, dout_valid drops immediately (asynchronous), no ack toggle.

Optional Feature:
- Macro: TOGGLE_HS_RX_SYNC_EN.
- Defined:
  - req_t passes through a 2-flop synchronizer before toggle detect, so the initiator may be in another clock domain.
  - Capture latency grows by 2 cycles: dout_valid rises after edge N+2.
  - data_in must be stable for the whole window.
- Undefined:
  - req_t is used directly; it must be synchronous to clk.
  - Latency as stated above.

Decomposition:
- Shared package/header toggle_hs_pkg:
  - State encodings IDLE=1'b0, HOLD=1'b1.
  - Default DATA_W=16.
  - Shared by the future toggle_hs_tx.
- Sub-module toggle_sync:
  - Parameterized 2-flop synchronizer with async clr.
  - Instantiated only under TOGGLE_HS_RX_SYNC_EN.

Test Plan:
1. Reset → apply clr=1 with req_t=0 → all outputs 0, state IDLE. Release, idle 5 cycles → no change.
2. Single transfer → data_in=16'hA5C3, toggle req_t 0→1, dout_ready=1 → next edge dout=16'hA5C3, dout_valid=1. Following edge ack_t=1, dout_valid=0, xfer_count=1.
3. Backpressure → toggle req_t with data 16'h1234, dout_ready=0 for 4 cycles → dout_valid and dout held, ack_t unchanged. Raise ready → one ack_t toggle, count +1.
4. Overrun → toggle req_t twice while in HOLD → overrun=1. After ready, exactly one ack_t toggle and count +1 only. overrun stays 1 until clr.
5. Wrap and stream → CNT_W=8, 256 transfers with ready=1 and alternating data 16'hFFFF/16'h0000 → every word matches, xfer_count returns to 0, ack_t ends at 0.
6. Reset mid-HOLD and sync build → assert clr while dout_valid=1 → dout_valid=0 immediately, no ack. With TOGGLE_HS_RX_SYNC_EN defined, rerun scenario 2 → dout_valid rises 2 cycles later.
